// File: rtl/fact_accel_pkg.sv
// Shared definitions for the factorial accelerator: FSM states, register
// offsets, STATUS bit positions and a configuration sanity helper.
package fact_accel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_GO     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  localparam int DONE_BIT = 0;
  localparam int ERR_BIT  = 1;

  // True when n! is representable in w bits, so the truncating multiply never wraps.
  function automatic bit fact_fits(input int n, input int w);
    longint unsigned f;
    f = 64'd1;
    if (w >= 64) return 1'b1;
    for (int i = 2; i <= n; i++) f = f * 64'(i);
    return f < (64'd1 << w);
  endfunction

endpackage

// File: rtl/fact_accel_if.sv
// One lane of the data-memory bus as seen by a memory-mapped peripheral.
interface fact_accel_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output sel, output we, output addr, output wd, input rd);
    modport slave  (input sel, input we, input addr, input wd, output rd);
endinterface

// File: rtl/fact_accel_fsm.sv
// Iterative factorial engine: counts down from n, multiplying into prod,
// and publishes the product (or an error) only on entry to DONE.
module fact_accel_fsm
    import fact_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_W-1:0]    n_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);
    localparam logic [N_W-1:0] ONE_V   = N_W'(1);

    state_e            state;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] prod;
    logic              err_pend;

    // NOTE: every register here updates with <= so all reads in this block see
    // the pre-edge values; blocking assignments would chain updates within a cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            prod     <= DATA_W'(1);
            err_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt      <= n_in;
                        prod     <= DATA_W'(1);
                        err_pend <= (n_in > MAX_N_V);
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (err_pend) begin
                        err    <= 1'b1;
                        result <= '0;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else if (cnt <= ONE_V) begin
                        done   <= 1'b1;
                        result <= prod;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        prod <= prod * DATA_W'(cnt);
                        cnt  <= cnt - ONE_V;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: bus decode, N register and read mux
// around the iterative engine.
module fact_accel
    import fact_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = 12
) (
    input  logic         clk,
    input  logic         rst,
    fact_accel_if.slave  bus,
    output logic         busy
);

    if (!fact_fits(MAX_N, DATA_W) || MAX_N >= (1 << N_W)) begin : g_bad_cfg
        $error("fact_accel: MAX_N! must fit in DATA_W and MAX_N must fit in N_W");
    end

    logic              wr;
    logic              start;
    logic [N_W-1:0]    n_reg;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    assign wr    = bus.sel & bus.we;
    assign start = wr && (bus.addr == OFF_GO) && bus.wd[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_reg <= '0;
        end else if (wr && (bus.addr == OFF_N)) begin
            n_reg <= bus.wd[N_W-1:0];
        end
    end

    // A GO in the same cycle as an N write cannot happen on one port, so the
    // engine always samples the already-registered n_reg.
    fact_accel_fsm #(
        .DATA_W (DATA_W),
        .N_W    (N_W),
        .MAX_N  (MAX_N)
    ) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_in   (n_reg),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    // NOTE: rd gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            OFF_N: bus.rd = DATA_W'(n_reg);
            OFF_STATUS: begin
                bus.rd[DONE_BIT] = done;
                bus.rd[ERR_BIT]  = err;
            end
            OFF_RESULT: bus.rd = result;
            default: bus.rd = '0;
        endcase
    end

endmodule
